step_sequencer: RTL and testbench

//  Control-unit timing front end that sits directly upstream of the control-signal encoder.

---
 rtl/step_sequencer.sv | 133 +++++++++++++
 tb/tb_step_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : step_sequencer
// Purpose  : Timing front end of the control unit. Accepts one instruction
//            word over a valid/ready handshake, latches it, then walks a
//            one-hot time-step vector forward one step per cycle until the
//            encoder signals End (or the last step is passed). Stall freezes
//            the current step.
// Ports    : clk, reset (async, active-high)
//            run, ins_valid, ins_in[INS_W], ins_ready   - instruction intake
//            stall, end_step                            - step control
//            T[STEPS], Ins[INS_W], busy                 - to encoder
//            step_overflow (sticky), instr_count[CNT_W] - status
// Revision : 1.0 - initial release
// ============================================================================
module step_sequencer #(
  parameter int STEPS = 16,
  parameter int INS_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             ins_valid,
  input  logic [INS_W-1:0] ins_in,
  output logic             ins_ready,
  input  logic             stall,
  input  logic             end_step,
  output logic [STEPS-1:0] T,
  output logic [INS_W-1:0] Ins,
  output logic             busy,
  output logic             step_overflow,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam logic [STEPS-1:0] c_T_FIRST = {{(STEPS-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [STEPS-1:0]   t_q,     t_d;
  logic [INS_W-1:0]   ins_q,   ins_d;
  logic               ready_q, ready_d;
  logic               busy_q,  busy_d;
  logic               ovf_q,   ovf_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      ins_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      ins_q   <= ins_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    ins_d   = ins_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        // ready is a registered copy of run, so a rising run opens the
        // handshake one edge later.
        ready_d = run;
        if (ins_valid && ready_q) begin
          ins_d   = ins_in;
          t_d     = c_T_FIRST;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = EXEC;
        end
      end

      EXEC: begin
        ready_d = 1'b0;
        if (end_step) begin
          // End takes priority over stall so a finished instruction always
          // retires on the step it reports.
          t_d     = '0;
          busy_d  = 1'b0;
          cnt_d   = cnt_q + c_CNT_ONE;
          ready_d = run;
          state_d = IDLE;
        end else if (stall) begin
          t_d = t_q;
        end else if (t_q[STEPS-1]) begin
          // Ran off the last step without End: abandon, flag sticky error.
          ovf_d   = 1'b1;
          t_d     = '0;
          busy_d  = 1'b0;
          ready_d = run;
          state_d = IDLE;
        end else begin
          t_d = t_q << 1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign T             = t_q;
  assign Ins           = ins_q;
  assign ins_ready     = ready_q;
  assign busy          = busy_q;
  assign step_overflow = ovf_q;
  assign instr_count   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_sequencer
// Purpose  : Directed self-checking bench for step_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        ins_valid;
  logic [3:0]  ins_in;
  logic        ins_ready;
  logic        stall;
  logic        end_step;
  logic [15:0] T;
  logic [3:0]  Ins;
  logic        busy;
  logic        step_overflow;
  logic [7:0]  instr_count;

  // end_step either follows T[5] (encoder ends on step 5) or a forced level
  logic        end_mode;
  logic        end_force;
  assign end_step = end_mode ? T[5] : end_force;

  int tests;
  int fails;

  step_sequencer #(.STEPS(16), .INS_W(4), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .ins_valid     (ins_valid),
    .ins_in        (ins_in),
    .ins_ready     (ins_ready),
    .stall         (stall),
    .end_step      (end_step),
    .T             (T),
    .Ins           (Ins),
    .busy          (busy),
    .step_overflow (step_overflow),
    .instr_count   (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_t;
    int          busy_cycles;

    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    run       = 1'b0;
    ins_valid = 1'b0;
    ins_in    = 4'b0000;
    stall     = 1'b0;
    end_mode  = 1'b0;
    end_force = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_T",     T, 0);
    chk("rst_Ins",   Ins, 0);
    chk("rst_ready", ins_ready, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ovf",   step_overflow, 0);
    chk("rst_cnt",   instr_count, 0);

    // ---------------- 1: basic run, end at T[5] ----------------
    @(negedge clk);
    reset     = 1'b0;
    run       = 1'b1;
    ins_valid = 1'b1;
    ins_in    = 4'b0001;
    end_mode  = 1'b1;
    tick();
    chk("t1_ready_rise", ins_ready, 1);
    chk("t1_idle_T",     T, 0);
    tick();
    chk("t1_accept_T",     T, 16'h0001);
    chk("t1_accept_Ins",   Ins, 4'b0001);
    chk("t1_accept_ready", ins_ready, 0);
    ins_valid   = 1'b0;
    exp_t       = 16'h0001;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      chk("t1_T_step", T, exp_t);
      busy_cycles++;
      exp_t = exp_t << 1;
      tick();
    end
    chk("t1_busy_cycles", busy_cycles, 6);
    chk("t1_T_idle",      T, 0);
    chk("t1_cnt",         instr_count, 1);
    chk("t1_ready_after", ins_ready, 1);

    // ---------------- 2: stall at T=8 ----------------
    ins_valid = 1'b1;
    ins_in    = 4'b0010;
    tick();
    chk("t2_accept_T", T, 16'h0001);
    ins_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("t2_T8", T, 16'h0008);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_T", T, 16'h0008);
    end
    stall = 1'b0;
    tick();
    chk("t2_T16", T, 16'h0010);
    tick();
    chk("t2_T32", T, 16'h0020);
    tick();
    chk("t2_T_end", T, 0);
    chk("t2_cnt",   instr_count, 2);
    chk("t2_Ins_hold", Ins, 4'b0010);

    // ---------------- 3: end and stall together ----------------
    ins_valid = 1'b1;
    ins_in    = 4'b0100;
    tick();
    ins_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t3_T32", T, 16'h0020);
    stall = 1'b1;
    tick();
    chk("t3_T_end", T, 0);
    chk("t3_busy",  busy, 0);
    chk("t3_cnt",   instr_count, 3);
    stall = 1'b0;

    // ---------------- 4: overflow past last step ----------------
    end_mode  = 1'b0;
    end_force = 1'b0;
    ins_valid = 1'b1;
    ins_in    = 4'b1000;
    tick();
    chk("t4_accept_T", T, 16'h0001);
    ins_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("t4_T_last", T, 16'h8000);
    chk("t4_ovf_pre", step_overflow, 0);
    tick();
    chk("t4_T_zero", T, 0);
    chk("t4_ovf",    step_overflow, 1);
    chk("t4_cnt",    instr_count, 3);
    chk("t4_busy",   busy, 0);
    chk("t4_ready",  ins_ready, 1);
    ins_valid = 1'b1;
    ins_in    = 4'b0011;
    tick();
    chk("t4_next_T",   T, 16'h0001);
    chk("t4_next_Ins", Ins, 4'b0011);
    ins_valid = 1'b0;
    end_mode  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_next_T32", T, 16'h0020);
    run = 1'b0;  // low during EXEC: current instruction still completes
    tick();
    chk("t4_next_cnt", instr_count, 4);
    chk("t4_ovf_sticky", step_overflow, 1);

    // ---------------- 5: run low blocks acceptance ----------------
    ins_valid = 1'b1;
    ins_in    = 4'b0101;
    tick();
    chk("t5_ready_lo", ins_ready, 0);
    tick();
    chk("t5_ready_lo2", ins_ready, 0);
    chk("t5_T_zero",    T, 0);
    run = 1'b1;
    tick();
    chk("t5_ready_hi", ins_ready, 1);
    chk("t5_T_still0", T, 0);
    tick();
    chk("t5_accept_T",   T, 16'h0001);
    chk("t5_accept_Ins", Ins, 4'b0101);
    ins_valid = 1'b0;

    // ---------------- 6: async reset mid-EXEC ----------------
    tick();
    tick();
    chk("t6_T4", T, 16'h0004);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_T",    T, 0);
    chk("t6_async_Ins",  Ins, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_cnt",  instr_count, 0);
    chk("t6_async_ovf",  step_overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("t6_ready_after_rst", ins_ready, 1);

    // back-to-back instructions with End held high: 2 edges each
    end_mode  = 1'b0;
    end_force = 1'b1;
    ins_valid = 1'b1;
    ins_in    = 4'b0001;
    for (int i = 0; i < 510; i++) tick();
    chk("t6_cnt_255", instr_count, 255);
    tick();
    chk("t6_busy_last", busy, 1);
    tick();
    chk("t6_cnt_wrap", instr_count, 0);
    chk("t6_T_idle",   T, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
